hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised pipeline-control block for the multi-stage CPU.
- Tracks the destination register, write-enable and load flag of every in-flight instruction in the DEPTH pipeline registers after decode (ID/EX, EX/MEM, MEM/WB for DEPTH=3).
- Detects load-use hazards and generates stall and bubble controls.
- Handles branch flush from EX.
- Produces registered forwarding selects for the EX-stage operand muxes, so the pipeline no longer needs hand-scheduled NOPs.

Parameters:
- REG_AW, 5, register-address width.
- DEPTH, 3, number of tracked pipeline registers after ID (min 2).
- LOAD_READY, 3, first stage index whose load result can be forwarded (2 ≤ LOAD_READY ≤ DEPTH).
- CNT_W, 16, stall-counter width.
- Derived constant SEL_W = clog2(DEPTH+1).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- id_valid  in  1  instruction in ID is real (not a bubble).
- id_rs  in  REG_AW  source A register.
- id_rt  in  REG_AW  source B register.
- id_uses_rs  in  1  source A is read.
- id_uses_rt  in  1  source B is read.
- id_rd  in  REG_AW  destination register.
- id_we  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a memory read.
- ex_branch_taken  in  1  branch in stage 1 resolved taken this cycle.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  invalidate IF/ID and ID.
- bubble_idex  out  1  load a NOP into ID/EX at the next edge.
- fwd_sel_a  out  SEL_W  registered operand-A select (0 = register file, k = stage k).
- fwd_sel_b  out  SEL_W  registered operand-B select, same encoding.
- stage_valid  out  DEPTH  valid bit of each tracked stage (bit k-1 = stage k).
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: per stage k=1..DEPTH, the entry {valid, rd, we, is_load}.
- Each edge: stage k+1 ← stage k; the entry from stage DEPTH retires. Stage 1 ← ID entry, or an invalid bubble when bubble_idex=1.
- Match(k, r): stage k valid, we=1, rd==r, r≠0, and the corresponding uses bit set.
- Source resolution, per source: take the youngest (lowest k) k<DEPTH with Match. Matches at k=DEPTH are ignored; the register file is write-first next cycle.
- Stall rule: hazard if the youngest match is a load and k+1 < LOAD_READY. Default config: load in stage 1 stalls one cycle.
- stall = id_valid & (hazard_a | hazard_b) & ~ex_branch_taken. Combinational, same cycle.
- Flush: flush_ifid = ex_branch_taken. Combinational.
- bubble_idex = stall | ex_branch_taken.
- Simultaneous stall and branch: flush wins. stall=0; the ID instruction is discarded, not held.
- Forwarding: at the edge the ID entry enters stage 1, fwd_sel_x ← k+1 for the youngest non-hazard match, else 0.
  - When bubble_idex=1, fwd_sel_a/b ← 0.
  - Latency: one cycle, aligned with the ID/EX register.
- id_valid=0 → no hazard, selects 0, and a bubble entry enters stage 1.
- stall_count increments on every cycle with stall=1 and saturates at all-ones; it does not wrap.
- Reset (reset_n=0 at an edge):
  - All stage entries invalid; fwd_sel_a/b=0; stall_count=0.
  - Combinational outputs follow the cleared state.
  - Reset mid-stall drops the stall on the next cycle.
  - Takes priority over all other updates.

Decomposition:
- Shared package hazard_pkg: the stage-entry struct {valid, rd, we, is_load}, the FWD_RF=0 select constant, and a clog2 function.
- One sub-module, hazard_match: a combinational priority search over the stage entries for one source register, returning {found, stage, is_hazard}. Instantiated twice (source A and source B).

Test Plan:
- ALU chain: add r1 → next instruction reads r1. No stall; fwd_sel_a=2 in its EX cycle. Third instruction reading r1 gets fwd_sel=3.
- Load-use: lw r2, then add reads r2. stall=1 and bubble_idex=1 for exactly one cycle. Next cycle fwd_sel_b=3; stall_count=1.
- r0 / unused: producer writes r0, or consumer has id_uses_rs=0. No stall; fwd_sel=0.
- Double producer: two writers of r3 back-to-back, then a consumer. fwd_sel=2 (the youngest), not 3.
- Branch during load-use: ex_branch_taken=1 while a load hazard is present. stall=0, flush_ifid=1, bubble_idex=1; stall_count unchanged.
- Reset mid-stall: reset_n=0 for one edge with a load in stage 1. stage_valid=0, fwd_sel=0, stall_count=0, stall=0 next cycle. With CNT_W=2, four stalls leave stall_count=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: the tracked
// stage entry, the register-file forwarding select and a ceiling-log2 helper.
package hazard_pkg;

    // Stage entries store rd at this fixed width; REG_AW must not exceed it.
    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_entry_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search over the forwardable stage entries for one source operand:
// reports the youngest matching producer and whether it is a load not yet ready.
module hazard_match import hazard_pkg::*; #(
    parameter int N          = 2,
    parameter int LOAD_READY = 3,
    parameter int SEL_W      = 2
) (
    input  stage_entry_t [N-1:0] stages,
    input  logic [MAX_AW-1:0]    src,
    input  logic                 uses,
    output logic                 found,
    output logic [SEL_W-1:0]     stage,
    output logic                 is_hazard
);

    logic hit_s;

    // Oldest to youngest so the youngest (index 0 = stage 1) match wins.
    always_comb begin
        found     = 1'b0;
        stage     = SEL_W'(FWD_RF);
        is_hazard = 1'b0;
        hit_s     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            hit_s     = uses && stages[k].valid && stages[k].we &&
                        (stages[k].rd == src) && (src != {MAX_AW{1'b0}});
            found     = found | hit_s;
            // Next cycle the producer sits one stage further, at k+2.
            stage     = hit_s ? SEL_W'(k + 2) : stage;
            is_hazard = hit_s ? (stages[k].is_load && ((k + 2) < LOAD_READY)) : is_hazard;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations, raises load-use
// stalls, handles branch flush and registers the EX operand forwarding selects.
module hazard_ctrl import hazard_pkg::*; #(
    parameter  int REG_AW     = 5,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 3,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [CNT_W-1:0]  stall_count
);

    stage_entry_t [DEPTH-1:0] stage_r;
    stage_entry_t             id_entry_s;
    logic [MAX_AW-1:0]        rs_ext_s;
    logic [MAX_AW-1:0]        rt_ext_s;
    logic [SEL_W-1:0]         fwd_sel_a_r;
    logic [SEL_W-1:0]         fwd_sel_b_r;
    logic [SEL_W-1:0]         sel_a_nxt_s;
    logic [SEL_W-1:0]         sel_b_nxt_s;
    logic [CNT_W-1:0]         stall_count_r;
    logic                     found_a_s;
    logic                     found_b_s;
    logic [SEL_W-1:0]         stage_a_s;
    logic [SEL_W-1:0]         stage_b_s;
    logic                     hazard_a_s;
    logic                     hazard_b_s;
    logic                     accept_s;
    logic                     unused_retire_s;

    // Widen ID register addresses to the stored entry width.
    always_comb begin
        rs_ext_s = MAX_AW'(id_rs);
        rt_ext_s = MAX_AW'(id_rt);
    end

    // The oldest stage is excluded: the register file is write-first for it.
    hazard_match #(
        .N          (DEPTH - 1),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_a (
        .stages    (stage_r[DEPTH-2:0]),
        .src       (rs_ext_s),
        .uses      (id_uses_rs),
        .found     (found_a_s),
        .stage     (stage_a_s),
        .is_hazard (hazard_a_s)
    );

    hazard_match #(
        .N          (DEPTH - 1),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_b (
        .stages    (stage_r[DEPTH-2:0]),
        .src       (rt_ext_s),
        .uses      (id_uses_rt),
        .found     (found_b_s),
        .stage     (stage_b_s),
        .is_hazard (hazard_b_s)
    );

    // Stall/flush/bubble decisions; a taken branch discards ID rather than holding it.
    always_comb begin
        stall       = id_valid & (hazard_a_s | hazard_b_s) & ~ex_branch_taken;
        flush_ifid  = ex_branch_taken;
        bubble_idex = stall | ex_branch_taken;
        accept_s    = id_valid & ~bubble_idex;
    end

    // Entry that enters stage 1 and the operand selects that travel with it.
    always_comb begin
        id_entry_s.valid   = accept_s;
        id_entry_s.rd      = MAX_AW'(id_rd);
        id_entry_s.we      = id_we;
        id_entry_s.is_load = id_is_load;
        sel_a_nxt_s        = (accept_s && found_a_s) ? stage_a_s : SEL_W'(FWD_RF);
        sel_b_nxt_s        = (accept_s && found_b_s) ? stage_b_s : SEL_W'(FWD_RF);
    end

    // Stage shift register; the oldest entry retires.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stage_r <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage_r[k] <= stage_r[k-1];
            end
            stage_r[0] <= id_entry_s;
        end
    end

    // Forwarding selects, aligned with the ID/EX register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fwd_sel_a_r <= SEL_W'(FWD_RF);
            fwd_sel_b_r <= SEL_W'(FWD_RF);
        end else begin
            fwd_sel_a_r <= sel_a_nxt_s;
            fwd_sel_b_r <= sel_b_nxt_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Expose per-stage valid bits and registered state.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_valid[k] = stage_r[k].valid;
        end
        fwd_sel_a   = fwd_sel_a_r;
        fwd_sel_b   = fwd_sel_b_r;
        stall_count = stall_count_r;
    end

    // Fields of the retiring entry are never consulted.
    assign unused_retire_s = ^{stage_r[DEPTH-1].rd, stage_r[DEPTH-1].we, stage_r[DEPTH-1].is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, checked against a queue-based pipeline model.
module tb_hazard_ctrl;

    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 3;

    logic       clock = 1'b0;
    logic       reset_n, id_valid, id_uses_rs, id_uses_rt, id_we, id_is_load, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall, flush_ifid, bubble_idex;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [2:0] stage_valid;
    logic [15:0] stall_count;
    logic       stall2, flush2, bubble2;
    logic [1:0] fa2, fb2;
    logic [2:0] sv2;
    logic [1:0] cnt2;

    always #5 clock = ~clock;

    hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(stall),
        .flush_ifid(flush_ifid), .bubble_idex(bubble_idex), .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b), .stage_valid(stage_valid), .stall_count(stall_count)
    );

    hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .stall(stall2),
        .flush_ifid(flush2), .bubble_idex(bubble2), .fwd_sel_a(fa2),
        .fwd_sel_b(fb2), .stage_valid(sv2), .stall_count(cnt2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: in-flight instructions, youngest first.
    typedef struct { bit v; int rd; bit we; bit ld; } ins_t;
    ins_t pipe[$];
    int   m_sel_a, m_sel_b, m_cnt, m_cnt2;
    bit   known = 1'b0;
    bit   obs_stall, obs_flush, obs_bub;

    function automatic void lookup(input int r, input bit use_r, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (use_r && r != 0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (pipe[i].v && pipe[i].we && pipe[i].rd == r) begin
                    sel = i + 2;
                    haz = pipe[i].ld && (i + 2 < LOAD_READY);
                    break;
                end
            end
        end
    endfunction

    task automatic step(input bit rn, input bit v, input int rs, input bit ua, input int rt,
                        input bit ub, input int rd, input bit we, input bit ld, input bit br);
        int   sa, sb;
        bit   ha, hb, e_stall, e_bub, acc;
        ins_t n;
        logic [2:0] e_sv;
        reset_n = rn; id_valid = v; id_rs = 5'(rs); id_uses_rs = ua; id_rt = 5'(rt);
        id_uses_rt = ub; id_rd = 5'(rd); id_we = we; id_is_load = ld; ex_branch_taken = br;
        #1;
        lookup(rs, ua, sa, ha);
        lookup(rt, ub, sb, hb);
        e_stall = v && (ha || hb) && !br;
        e_bub   = e_stall || br;
        if (known) begin
            chk("stall", stall, e_stall);
            chk("flush", flush_ifid, br);
            chk("bubble", bubble_idex, e_bub);
            chk("stall2", stall2, e_stall);
            chk("bubble2", bubble2, e_bub);
            chk("flush2", flush2, br);
        end
        obs_stall = stall; obs_flush = flush_ifid; obs_bub = bubble_idex;
        @(posedge clock);
        acc = v && !e_bub;
        if (!rn) begin
            pipe = {};
            for (int i = 0; i < DEPTH; i++) begin
                n.v = 1'b0; n.rd = 0; n.we = 1'b0; n.ld = 1'b0;
                pipe.push_back(n);
            end
            m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_cnt2 = 0;
            known = 1'b1;
        end else begin
            n.v = acc; n.rd = rd; n.we = we; n.ld = ld;
            pipe.push_front(n);
            void'(pipe.pop_back());
            m_sel_a = acc ? sa : 0;
            m_sel_b = acc ? sb : 0;
            if (e_stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) e_sv[i] = pipe[i].v;
        if (known) begin
            chk("fwd_a", fwd_sel_a, m_sel_a);
            chk("fwd_b", fwd_sel_b, m_sel_b);
            chk("stage_valid", stage_valid, e_sv);
            chk("count", stall_count, m_cnt);
            chk("count2", cnt2, m_cnt2);
            chk("fwd_a2", fa2, m_sel_a);
            chk("fwd_b2", fb2, m_sel_b);
            chk("stage_valid2", sv2, e_sv);
        end
    endtask

    initial begin
        int  rs, rt, rd;
        bit  v, ua, ub, we, ld, br, rn;
        @(negedge clock);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_sv", stage_valid, 0);
        chk("rst_cnt", stall_count, 0);

        // Load-use: one stall, then operand B from stage 3.
        step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
        step(1, 1, 0, 0, 2, 1, 5, 1, 0, 0);
        chk("lu_stall", obs_stall, 1);
        chk("lu_bubble", obs_bub, 1);
        step(1, 1, 0, 0, 2, 1, 5, 1, 0, 0);
        chk("lu_nostall", obs_stall, 0);
        chk("lu_fwd_b", fwd_sel_b, 3);
        chk("lu_cnt", stall_count, 1);

        // ALU chain.
        step(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0, 6, 1, 0, 0);
        chk("alu_fwd2", fwd_sel_a, 2);
        step(1, 1, 1, 1, 0, 0, 7, 1, 0, 0);
        chk("alu_fwd3", fwd_sel_a, 3);

        // r0 producer and unused source.
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0, 8, 1, 0, 0);
        chk("r0_fwd", fwd_sel_a, 0);
        step(1, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        step(1, 1, 4, 0, 0, 0, 9, 1, 0, 0);
        chk("unused_stall", obs_stall, 0);
        chk("unused_fwd", fwd_sel_a, 0);

        // Double producer: youngest wins.
        step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        step(1, 1, 3, 1, 0, 0, 10, 1, 0, 0);
        chk("dbl_fwd", fwd_sel_a, 2);

        // Branch during load-use: flush wins.
        step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
        step(1, 1, 0, 0, 2, 1, 11, 1, 0, 1);
        chk("br_stall", obs_stall, 0);
        chk("br_flush", obs_flush, 1);
        chk("br_bubble", obs_bub, 1);
        chk("br_cnt", stall_count, 1);

        // Reset mid-stall.
        step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
        step(0, 1, 0, 0, 2, 1, 12, 1, 0, 0);
        chk("rm_stall_before", obs_stall, 1);
        chk("rm_sv", stage_valid, 0);
        chk("rm_fwd", fwd_sel_b, 0);
        chk("rm_cnt", stall_count, 0);
        step(1, 1, 0, 0, 2, 1, 12, 1, 0, 0);
        chk("rm_stall_after", obs_stall, 0);

        // Four stalls saturate a 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
            step(1, 1, 2, 1, 0, 0, 13, 1, 0, 0);
            step(1, 1, 2, 1, 0, 0, 13, 1, 0, 0);
        end
        chk("sat_cnt2", cnt2, 3);
        chk("sat_cnt", stall_count, 4);

        // Random instruction stream; ID is held while stalled.
        v = 1'b0; rs = 0; rt = 0; rd = 0; ua = 1'b0; ub = 1'b0; we = 1'b0; ld = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            br = ($urandom_range(0, 9) == 0);
            if (!obs_stall || !rn) begin
                v  = ($urandom_range(0, 6) != 0);
                rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
                ua = $urandom_range(0, 1); ub = $urandom_range(0, 1);
                we = ($urandom_range(0, 4) != 0); ld = $urandom_range(0, 1);
            end
            step(rn, v, rs, ua, rt, ub, rd, we, ld, br);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
